// File: rtl/q2_clock_pkg.sv
// Shared constants and FSM encoding for the front-panel run controller.
package q2_clock_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned CYC_W               = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2,
        ST_STEP     = 2'd3
    } run_state_e;

endpackage

// File: rtl/q2_debounce.sv
// Button conditioner: 2-flop synchronizer, level debouncer, press-edge pulse.
module q2_debounce
    import q2_clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_n,
    output logic press_p
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d_q;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // One-cycle registered pulse on a debounced high-to-low (press) transition.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            level_d_q <= 1'b1;
            press_p   <= 1'b0;
        end else begin
            level_d_q <= level_q;
            press_p   <= level_d_q & ~level_q;
        end
    end

endmodule

// File: rtl/q2_run_ctrl.sv
// Front-panel run/stop/step controller gating the CPU oscillator and state advance.
module q2_run_ctrl
    import q2_clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             nstart_btn,
    input  logic             nstop_btn,
    input  logic             nstep_btn,
    input  logic             instr_end,
    input  logic             halt,
    output logic             nstop,
    output logic             run_en,
    output logic             cdiv,
    output logic             ncdiv,
    output logic             halted,
    output logic [CYC_W-1:0] cyc_count
);

    logic       start_p;
    logic       stop_p;
    logic       step_p;
    run_state_e state_q;
    run_state_e state_d;
    logic       halt_set;
    logic       halt_clr;

    q2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk     (clk),
        .nrst    (nrst),
        .btn_n   (nstart_btn),
        .press_p (start_p)
    );

    q2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_stop (
        .clk     (clk),
        .nrst    (nrst),
        .btn_n   (nstop_btn),
        .press_p (stop_p)
    );

    q2_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk     (clk),
        .nrst    (nrst),
        .btn_n   (nstep_btn),
        .press_p (step_p)
    );

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and halt-status control; RUN only leaves on a halt or a pending stop.
    always_comb begin
        state_d  = state_q;
        halt_set = 1'b0;
        halt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d  = ST_RUN;
                    halt_clr = 1'b1;
                end else if (step_p) begin
                    state_d  = ST_STEP;
                    halt_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (instr_end && (halt || stop_p)) begin
                    state_d  = ST_IDLE;
                    halt_set = halt;
                end else if (stop_p) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (instr_end) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (instr_end) begin
                    state_d  = ST_IDLE;
                    halt_set = halt;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered run gates track the state being entered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_en <= 1'b0;
            nstop  <= 1'b0;
        end else begin
            run_en <= (state_d != ST_IDLE);
            nstop  <= (state_d != ST_IDLE);
        end
    end

    // Phase divider pair advances only while the CPU is enabled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cdiv  <= 1'b0;
            ncdiv <= 1'b1;
        end else if (run_en) begin
            cdiv  <= ~cdiv;
            ncdiv <= cdiv;
        end
    end

    // Sticky halt flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            halted <= 1'b0;
        end else if (halt_set) begin
            halted <= 1'b1;
        end else if (halt_clr) begin
            halted <= 1'b0;
        end
    end

    // Free-running count of enabled cycles; wraps naturally.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cyc_count <= '0;
        end else if (run_en) begin
            cyc_count <= cyc_count + CYC_W'(1);
        end
    end

endmodule

// File: tb/tb_q2_run_ctrl.sv
// Self-checking bench for q2_run_ctrl with a short debounce window.
module tb_q2_run_ctrl;

    localparam int unsigned DB = 4;

    logic        clk;
    logic        nrst;
    logic        nstart_btn;
    logic        nstop_btn;
    logic        nstep_btn;
    logic        instr_end;
    logic        halt;
    logic        nstop;
    logic        run_en;
    logic        cdiv;
    logic        ncdiv;
    logic        halted;
    logic [15:0] cyc_count;

    int total = 0;
    int bad   = 0;

    // st: 0 IDLE, 1 RUN, 2 STEP, 3 STOPPING; btn bits {start, stop, step}
    typedef struct {
        int       st;
        logic [2:0] btn;
        logic     ie;
        logic     hl;
        logic     exp_run_a;
        logic     exp_halted;
        logic     exp_run_b;
    } vec_t;

    vec_t       vecs [16];
    logic [2:0] exp_q [$];

    q2_run_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .nstart_btn (nstart_btn),
        .nstop_btn  (nstop_btn),
        .nstep_btn  (nstep_btn),
        .instr_end  (instr_end),
        .halt       (halt),
        .nstop      (nstop),
        .run_en     (run_en),
        .cdiv       (cdiv),
        .ncdiv      (ncdiv),
        .halted     (halted),
        .cyc_count  (cyc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        nstart_btn = 1'b1;
        nstop_btn  = 1'b1;
        nstep_btn  = 1'b1;
        instr_end  = 1'b0;
        halt       = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Drive buttons low; returns in the cycle whose closing edge consumes the press pulse.
    task automatic press(input logic [2:0] b);
        nstart_btn = ~b[2];
        nstop_btn  = ~b[1];
        nstep_btn  = ~b[0];
        repeat (DB + 3) @(negedge clk);
    endtask

    task automatic release_all();
        nstart_btn = 1'b1;
        nstop_btn  = 1'b1;
        nstep_btn  = 1'b1;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic goto_state(input int st);
        do_reset();
        if (st == 1 || st == 3) begin
            press(3'b100);
            @(negedge clk);
            release_all();
        end
        if (st == 2) begin
            press(3'b001);
            @(negedge clk);
            release_all();
        end
        if (st == 3) begin
            press(3'b010);
            @(negedge clk);
            release_all();
        end
    endtask

    initial begin
        int   hi;
        logic saw;
        logic [2:0] e;
        vec_t v;

        nrst       = 1'b0;
        nstart_btn = 1'b1;
        nstop_btn  = 1'b1;
        nstep_btn  = 1'b1;
        instr_end  = 1'b0;
        halt       = 1'b0;

        //           st  btn     ie    hl    run_a halted run_b
        vecs[0]  = '{0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{0, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{0, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{3, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        check("rst run_en", run_en, 0);
        check("rst nstop", nstop, 0);
        check("rst cdiv", cdiv, 0);
        check("rst ncdiv", ncdiv, 1);
        check("rst halted", halted, 0);
        check("rst cyc_count", cyc_count, 0);

        // Table-driven FSM transitions
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            goto_state(v.st);
            press(v.btn);
            instr_end = v.ie;
            halt      = v.hl;
            exp_q.push_back({v.exp_run_a, v.exp_halted, v.exp_run_b});
            @(negedge clk);
            instr_end = 1'b0;
            halt      = 1'b0;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL v%0d scoreboard: got empty want entry", i);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d run_en", i), run_en, e[2]);
                check($sformatf("v%0d nstop", i), nstop, e[2]);
                check($sformatf("v%0d halted", i), halted, e[1]);
                release_all();
                instr_end = 1'b1;
                @(negedge clk);
                instr_end = 1'b0;
                check($sformatf("v%0d run_en after instr_end", i), run_en, e[0]);
            end
        end

        // Glitchy start presses shorter than the window, then a solid press
        do_reset();
        saw = 1'b0;
        for (int g = 0; g < 3; g++) begin
            nstart_btn = 1'b0;
            repeat (3) begin @(negedge clk); saw |= run_en; end
            nstart_btn = 1'b1;
            repeat (3) begin @(negedge clk); saw |= run_en; end
        end
        repeat (8) begin @(negedge clk); saw |= run_en; end
        check("glitch no run", saw, 0);
        nstart_btn = 1'b0;
        repeat (DB + 3) @(negedge clk);
        check("start before pulse edge", run_en, 0);
        @(negedge clk);
        check("start run_en", run_en, 1);
        check("start nstop", nstop, 1);
        repeat (12) @(negedge clk);
        nstart_btn = 1'b1;
        check("start cyc_count", cyc_count, 12);

        // Single step lasting six enabled cycles
        do_reset();
        press(3'b001);
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (run_en) hi++;
            if (i == 1) check("step cdiv mid", {cdiv, ncdiv}, 16'h2);
            instr_end = (i == 5);
            @(negedge clk);
        end
        nstep_btn = 1'b1;
        check("step run_en cycles", 16'(hi), 6);
        check("step cyc_count", cyc_count, 6);
        check("step cdiv", cdiv, 0);
        check("step ncdiv", ncdiv, 1);

        // Stop request waits ten cycles for the instruction end
        goto_state(1);
        press(3'b010);
        @(negedge clk);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (run_en) hi++;
            instr_end = (i == 9);
            @(negedge clk);
        end
        nstop_btn = 1'b1;
        check("stopping cycles", 16'(hi), 10);
        check("stopping idle", run_en, 0);

        // Halt then restart clears the halt flag
        goto_state(1);
        instr_end = 1'b1;
        halt      = 1'b1;
        @(negedge clk);
        instr_end = 1'b0;
        halt      = 1'b0;
        check("halt run_en", run_en, 0);
        check("halt halted", halted, 1);
        press(3'b100);
        @(negedge clk);
        check("restart halted", halted, 0);
        check("restart run_en", run_en, 1);
        release_all();

        // Button held through reset release gives a press
        nstart_btn = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (DB + 3) @(negedge clk);
        check("held-reset before", run_en, 0);
        @(negedge clk);
        check("held-reset run_en", run_en, 1);

        // Counter wrap
        do_reset();
        press(3'b100);
        @(negedge clk);
        check("wrap start count", cyc_count, 0);
        nstart_btn = 1'b1;
        repeat (65535) @(negedge clk);
        check("wrap ffff", cyc_count, 16'hFFFF);
        @(negedge clk);
        check("wrap 0000", cyc_count, 16'h0000);

        // Asynchronous reset mid-run
        #2 nrst = 1'b0;
        #1;
        check("async run_en", run_en, 0);
        check("async nstop", nstop, 0);
        check("async cdiv", cdiv, 0);
        check("async ncdiv", ncdiv, 1);
        check("async halted", halted, 0);
        check("async cyc_count", cyc_count, 0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
